// File: rtl/mem_inst_reader.sv
// rtl/mem_inst_reader.sv - burst reader fetching consecutive memory words onto a valid/ready output
module mem_inst_reader #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wEn,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        OUT,
        DONE
    } state_t;

    // A burst can never exceed the full memory size.
    localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_WORD  = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   count_clamped;

    // The reader only ever reads.
    assign mem_wEn = 1'b0;

    // cur_addr only moves at burst start or on a handshake, so it already holds
    // its last value while idle.
    assign mem_addr = cur_addr;

    // Oversized requests are trimmed to one full pass over the memory.
    always_comb begin
        count_clamped = (count > MAX_COUNT) ? MAX_COUNT : count;
    end

    // Burst sequencing: address the word, capture it, hold it until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count_clamped != '0) begin
                            cur_addr  <= base_addr;
                            remaining <= count_clamped;
                            busy      <= 1'b1;
                            state     <= RD;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                RD: begin
                    if (abort) begin
                        remaining <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        state <= CAP;
                    end
                end
                CAP: begin
                    if (abort) begin
                        remaining <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        out_data  <= mem_rdata;
                        out_addr  <= cur_addr;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    // Abort beats a simultaneous handshake: the word is dropped.
                    if (abort) begin
                        remaining <= '0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (remaining == ONE_WORD) begin
                            remaining <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            remaining <= remaining - ONE_WORD;
                            cur_addr  <= cur_addr + 1'b1;
                            state     <= RD;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_inst_reader.sv
// tb/tb_mem_inst_reader.sv - randomized and directed bench for mem_inst_reader against a timing model
module tb_mem_inst_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  base_addr = '0;
    logic [9:0]  count = '0;
    logic        abort = 1'b0;
    logic [8:0]  mem_addr;
    logic        mem_wEn;
    logic [31:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [8:0]  out_addr;
    logic        busy;
    logic        done;

    mem_inst_reader #(.ADDR_W(9), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .abort(abort), .mem_addr(mem_addr), .mem_wEn(mem_wEn), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // synchronous-read memory
    logic [31:0] mem [512];
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    // behavioural model: words left, a countdown to the next presented word,
    // and the address/data of the word on offer
    int          cyc = 0;
    bit          m_active = 0;
    bit          m_valid = 0;
    bit          m_done = 0;
    int          m_cur = 0;
    int          m_left = 0;
    int          m_delay = 0;
    logic [31:0] m_data = '0;
    int          m_addr = 0;

    always @(posedge clk) begin
        int n;
        cyc++;
        if (rst) begin
            m_active = 0; m_valid = 0; m_done = 0; m_cur = 0; m_left = 0;
            m_delay = 0; m_data = '0; m_addr = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_active) begin
            if (start) begin
                n = (int'(count) > 512) ? 512 : int'(count);
                if (n == 0) m_done = 1;
                else begin
                    m_active = 1; m_cur = int'(base_addr); m_left = n; m_delay = 2;
                end
            end
        end else if (abort) begin
            m_active = 0; m_valid = 0; m_left = 0;
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid = 0;
                m_left--;
                if (m_left == 0) begin
                    m_active = 0; m_done = 1;
                end else begin
                    m_cur = (m_cur + 1) % 512; m_delay = 2;
                end
            end
        end else begin
            m_delay--;
            if (m_delay == 0) begin
                m_valid = 1; m_data = mem[m_cur]; m_addr = m_cur;
            end
        end
    end

    // event logs for directed checks
    bit          cmp_en = 0;
    bit          prev_valid = 0;
    bit          busy_seen = 0;
    logic [31:0] hs_data_q[$];
    int          hs_addr_q[$];
    int          hs_cyc_q[$];
    int          vr_q[$];
    int          dn_q[$];

    // compare DUT against the model every cycle and log events
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("out_valid", out_valid, m_valid);
            chk("busy", busy, m_active);
            chk("done", done, m_done);
            chk("mem_addr", mem_addr, m_cur);
            chk("mem_wEn", mem_wEn, 0);
            chk("out_data", out_data, m_data);
            chk("out_addr", out_addr, m_addr);
            if (out_valid && out_ready && !abort && !rst) begin
                hs_data_q.push_back(out_data);
                hs_addr_q.push_back(int'(out_addr));
                hs_cyc_q.push_back(cyc);
            end
            if (out_valid && !prev_valid) vr_q.push_back(cyc);
            if (done) dn_q.push_back(cyc);
            if (busy) busy_seen = 1;
            prev_valid = out_valid;
        end
    end

    // consumer: 0 = always ready, 1 = random, 2 = stall 5 cycles on word 2
    int ready_mode = 0;
    int stall_n = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
                if (out_valid && hs_data_q.size() == 1 && stall_n < 5) begin
                    out_ready = 1'b0;
                    stall_n++;
                end else begin
                    out_ready = 1'b1;
                end
            end
        endcase
    end

    int s_cyc = 0;

    task automatic clr_logs();
        hs_data_q.delete(); hs_addr_q.delete(); hs_cyc_q.delete();
        vr_q.delete(); dn_q.delete(); busy_seen = 0;
    endtask

    task automatic pulse_start(input int b, input int c);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 9'(b); count = 10'(c); s_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_quiet(input int bound);
        int n = 0;
        @(posedge clk); #1;
        while ((busy || done) && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_quiet_timeout", n < bound, 1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 512; i++) mem[i] = $urandom;
        mem[200] = 32'h00000013;
        mem[201] = 32'h00100093;
        mem[202] = 32'h00208133;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1;
        @(posedge clk); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_addr", out_addr, 0);
        rst = 1'b0;

        // basic burst
        clr_logs();
        pulse_start(200, 3);
        wait_quiet(100);
        chk("basic_words", hs_data_q.size(), 3);
        if (hs_data_q.size() == 3) begin
            chk("basic_d0", hs_data_q[0], 32'h00000013);
            chk("basic_d1", hs_data_q[1], 32'h00100093);
            chk("basic_d2", hs_data_q[2], 32'h00208133);
            chk("basic_a0", hs_addr_q[0], 200);
            chk("basic_a2", hs_addr_q[2], 202);
            chk("basic_next_lat", hs_cyc_q[1] - hs_cyc_q[0], 3);
            chk("basic_first_lat", vr_q[0] - s_cyc, 3);
            chk("basic_done_lat", (dn_q.size() == 1) ? dn_q[0] - hs_cyc_q[2] : -1, 1);
        end

        // backpressure on word 2
        clr_logs();
        stall_n = 0;
        ready_mode = 2;
        pulse_start(200, 3);
        wait_quiet(100);
        ready_mode = 0;
        chk("bp_words", hs_data_q.size(), 3);
        chk("bp_stalls", stall_n, 5);
        if (hs_data_q.size() == 3) begin
            chk("bp_d1", hs_data_q[1], 32'h00100093);
            chk("bp_a1", hs_addr_q[1], 201);
            chk("bp_d2", hs_data_q[2], 32'h00208133);
            chk("bp_gap", hs_cyc_q[1] - hs_cyc_q[0], 8);
        end

        // wrap-around
        clr_logs();
        pulse_start(510, 4);
        wait_quiet(100);
        chk("wrap_words", hs_addr_q.size(), 4);
        if (hs_addr_q.size() == 4) begin
            chk("wrap_a0", hs_addr_q[0], 510);
            chk("wrap_a1", hs_addr_q[1], 511);
            chk("wrap_a2", hs_addr_q[2], 0);
            chk("wrap_a3", hs_addr_q[3], 1);
            chk("wrap_d2", hs_data_q[2], mem[0]);
        end

        // zero count
        clr_logs();
        pulse_start(77, 0);
        wait_quiet(20);
        chk("zero_words", hs_data_q.size(), 0);
        chk("zero_busy_seen", busy_seen, 0);
        chk("zero_done_lat", (dn_q.size() == 1) ? dn_q[0] - s_cyc : -1, 1);

        // clamp
        clr_logs();
        pulse_start(5, 600);
        wait_quiet(2000);
        chk("clamp_words", hs_data_q.size(), 512);
        chk("clamp_last_addr", (hs_addr_q.size() > 0) ? hs_addr_q[hs_addr_q.size()-1] : -1, 4);
        chk("clamp_done", dn_q.size(), 1);

        // abort on word 2 of 5 together with ready
        clr_logs();
        pulse_start(300, 5);
        n = 0;
        while (!(out_valid && hs_data_q.size() == 1) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_reach_word2", n < 50, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        repeat (6) @(posedge clk);
        #1;
        chk("abort_words", hs_data_q.size(), 1);
        chk("abort_no_done", dn_q.size(), 0);
        pulse_start(100, 1);
        wait_quiet(50);
        chk("abort_restart_words", hs_data_q.size(), 2);
        chk("abort_restart_data", (hs_data_q.size() == 2) ? hs_data_q[1] : 32'h0, mem[100]);
        chk("abort_restart_done", dn_q.size(), 1);

        // start while busy is ignored
        clr_logs();
        pulse_start(200, 3);
        pulse_start(0, 5);
        wait_quiet(100);
        chk("ign_words", hs_addr_q.size(), 3);
        chk("ign_a0", (hs_addr_q.size() == 3) ? hs_addr_q[0] : -1, 200);

        // reset in CAP
        clr_logs();
        pulse_start(201, 3);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_mem_addr", mem_addr, 0);
        chk("mrst_out_data", out_data, 0);
        chk("mrst_out_addr", out_addr, 0);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("mrst_words", hs_data_q.size(), 0);
        chk("mrst_no_done", dn_q.size(), 0);

        // randomized traffic, model-checked every cycle
        ready_mode = 1;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 399) == 0);
            start = ($urandom_range(0, 2) == 0);
            base_addr = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(505, 511)) : 9'($urandom);
            n = $urandom_range(0, 63);
            count = (n == 0) ? 10'd0 : (n == 1) ? 10'($urandom_range(513, 1023)) : 10'($urandom_range(1, 12));
            abort = ($urandom_range(0, 49) == 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        ready_mode = 0;
        repeat (5) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_inst_reader.md
MEM_INST_READER -- requirements
Module: mem_inst_reader

Interface
REQ-001 Parameter ADDR_W, default 9, memory word-address width (512 words).
REQ-002 Parameter DATA_W, default 32, memory word and instruction width.
REQ-003 The block SHALL run on one clock, with synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-004 Ports SHALL be:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a burst; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address of the burst.
- count  in  ADDR_W+1  number of words to read, 0..512.
- abort  in  1  cancel the active burst.
- mem_addr  out  ADDR_W  address to the memory.
- mem_wEn  out  1  memory write enable.
- mem_rdata  in  DATA_W  memory dout; valid one cycle after mem_addr is sampled.
- out_valid  out  1  out_data/out_addr hold a word.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_W  fetched word.
- out_addr  out  ADDR_W  address of out_data.
- busy  out  1  burst in progress.
- done  out  1  one-cycle burst-complete pulse.

Function
REQ-005 mem_wEn SHALL be constant 0; the block never writes the memory.
REQ-006 The FSM SHALL have five states: IDLE, RD, CAP, OUT and DONE.
REQ-007 IDLE:
- start=1 with count!=0 SHALL latch base_addr into cur_addr and count into remaining, then go to RD.
- start=1 with count=0 SHALL go to DONE, with no memory access.
- Values of count above 512 SHALL be clamped to 512.
REQ-008 RD: mem_addr SHALL equal cur_addr; the next state SHALL be CAP.
REQ-009 CAP: mem_rdata SHALL be registered into out_data and cur_addr into out_addr; the next state SHALL be OUT.
REQ-010 OUT: out_valid SHALL be 1; out_data and out_addr SHALL stay stable until a handshake (out_valid & out_ready).
REQ-011 On a handshake with remaining=1 the next state SHALL be DONE; otherwise remaining SHALL decrement, cur_addr SHALL increment modulo 2^ADDR_W (511 -> 0), and the next state SHALL be RD.
REQ-012 DONE: done SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-013 busy SHALL be 1 exactly in RD, CAP and OUT.
REQ-014 Latency SHALL be as follows:
- first out_valid = 3 cycles after the edge that samples start;
- each subsequent word = 3 cycles after the previous handshake;
- done = 1 cycle after the final handshake.
REQ-015 start while not in IDLE SHALL be ignored.
REQ-016 abort=1 in RD, CAP or OUT SHALL go to IDLE next cycle: out_valid drops, no done pulse, remaining is discarded.
REQ-017 abort=1 in IDLE or DONE SHALL have no effect; DONE still pulses.
REQ-018 When abort and out_ready coincide in OUT, abort SHALL win: the word counts as not consumed and no done pulse is produced.
REQ-019 mem_addr SHALL hold cur_addr in all states other than IDLE; in IDLE it SHALL hold its last value.

Reset
REQ-020 rst=1 SHALL force the state to IDLE and set mem_addr=0, out_valid=0, out_data=0, out_addr=0, busy=0, done=0, cur_addr=0 and remaining=0.
REQ-021 rst SHALL take priority over start and abort, and SHALL take effect from any state, including mid-burst, at the next edge.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Basic burst, ready held at 1: memory[200..202] = 00000013, 00100093, 00208133; start with base=200, count=3 -> three words in order, out_addr 200/201/202, first out_valid 3 cycles after start, done pulse 1 cycle after the third handshake.
- Backpressure: as above with out_ready=0 for 5 cycles on word 2 -> out_data=00100093 and out_addr=201 held stable, no extra memory reads, no duplicate or lost word.
- Wrap-around: base=510, count=4 -> out_addr 510, 511, 0, 1.
- Zero count / clamp: count=0 -> done one cycle after start, busy never 1; count=600 -> exactly 512 words.
- Abort: abort in OUT on word 2 of 5, coinciding with out_ready=1 -> state IDLE next cycle, out_valid=0, no done; a new start is then accepted.
- Reset mid-burst: rst during CAP -> all outputs 0 next cycle; start during busy is ignored.
